mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_starve_ctr.sv | 42 ++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, access owner
// and the default starvation limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch was waiting; flags when
// the fetch port is owed the next grant.
module mem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic data_gnt,
  input  logic fetch_gnt,
  input  logic if_req,
  output logic starved
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (fetch_gnt) begin
      starve_cnt_next = '0;
    end else if (data_gnt) begin
      if (!if_req) begin
        starve_cnt_next = '0;
      end else if (starve_cnt_reg != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign starved = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single-outstanding memory port, data preferred.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch win after STARVE_LIMIT data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [3:0]        mem_we_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              starved;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .data_gnt (d_gnt),
    .fetch_gnt(if_gnt),
    .if_req   (if_req),
    .starved  (starved)
  );
`else
  assign starved = 1'b0;
`endif

  // Grants and completion pulses are combinational; rst masks both so a
  // reset cycle never hands out or retires an access.
  always_comb begin
    state_next = state_reg;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_rvalid  = 1'b0;
    d_rvalid   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rst) begin
          if (d_req && !(if_req && starved)) begin
            d_gnt      = 1'b1;
            state_next = BUSY_D;
          end else if (if_req) begin
            if_gnt     = 1'b1;
            state_next = BUSY_I;
          end
        end
      end
      BUSY_I: begin
        if (mem_ack && !rst) begin
          if_rvalid  = 1'b1;
          state_next = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack && !rst) begin
          d_rvalid   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Requester inputs are captured only in the grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_addr_reg  <= '0;
      mem_we_reg    <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (d_gnt) begin
        mem_addr_reg  <= d_addr;
        mem_we_reg    <= d_we;
        mem_wdata_reg <= d_wdata;
      end else if (if_gnt) begin
        mem_addr_reg  <= if_addr;
        mem_we_reg    <= '0;
        mem_wdata_reg <= '0;
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign mem_req   = busy;
  assign mem_addr  = mem_addr_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queued requesters, a delay-programmable
// memory responder and a monitor that retires expected grants/completions.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        resp_ack, manual_ack;
  logic [31:0] resp_data, manual_data, ack_data;
  int          ack_delay;

  assign mem_ack   = resp_ack | manual_ack;
  assign mem_rdata = manual_ack ? manual_data : resp_data;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic own_d; int gap; } gnt_exp_t;
  typedef struct {
    logic own_d; logic [31:0] addr; logic [3:0] we; logic [31:0] wdata;
    logic [31:0] rdata; int lat;
  } rsp_exp_t;
  typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; } req_t;

  gnt_exp_t gnt_q[$];
  rsp_exp_t rsp_q[$];
  req_t     if_q[$];
  req_t     d_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requesters: hold req/addr until granted, then present the next queued entry.
  initial begin : if_requester
    logic taken;
    if_req = 1'b0; if_addr = '0;
    forever begin
      @(negedge clk); taken = if_gnt;
      @(posedge clk); #2;
      if (taken && if_q.size() > 0) void'(if_q.pop_front());
      if (if_q.size() > 0) begin if_req = 1'b1; if_addr = if_q[0].addr; end
      else begin if_req = 1'b0; if_addr = '0; end
    end
  end

  initial begin : d_requester
    logic taken;
    d_req = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0;
    forever begin
      @(negedge clk); taken = d_gnt;
      @(posedge clk); #2;
      if (taken && d_q.size() > 0) void'(d_q.pop_front());
      if (d_q.size() > 0) begin
        d_req = 1'b1; d_addr = d_q[0].addr; d_we = d_q[0].we; d_wdata = d_q[0].wdata;
      end else begin
        d_req = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0;
      end
    end
  end

  // Memory: acks ack_delay cycles after mem_req first appears.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0; resp_ack = 1'b0; resp_data = '0;
    forever begin
      @(posedge clk); #3;
      resp_ack = 1'b0; resp_data = '0;
      if (mem_req && !rst) begin
        if (wait_cnt >= ack_delay) begin
          resp_ack = 1'b1; resp_data = ack_data; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  gnt_exp_t g;
  rsp_exp_t r;
  int last_gnt_cyc = 0;
  int last_rv_cyc = 0;

  always @(negedge clk) begin
    if (if_gnt || d_gnt) begin
      if (gnt_q.size() == 0) begin
        chk("unexpected_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
      end else begin
        g = gnt_q.pop_front();
        chk("gnt_owner", 32'(d_gnt), 32'(g.own_d));
        chk("gnt_onehot", 32'(if_gnt & d_gnt), 32'd0);
        if (g.gap > 0) chk("gnt_gap_after_rvalid", 32'(cyc - last_rv_cyc), 32'(g.gap));
      end
      last_gnt_cyc = cyc;
    end
    if (if_rvalid || d_rvalid) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rv_owner", 32'(d_rvalid), 32'(r.own_d));
        chk("rv_onehot", 32'(if_rvalid & d_rvalid), 32'd0);
        chk("rdata", r.own_d ? d_rdata : if_rdata, r.rdata);
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_we", 32'(mem_we), 32'(r.we));
        if (r.own_d) chk("mem_wdata", mem_wdata, r.wdata);
        chk("mem_req_held", 32'(mem_req), 32'd1);
        chk("latency", 32'(cyc - last_gnt_cyc), 32'(r.lat));
        chk("no_gnt_in_ack", 32'(if_gnt | d_gnt), 32'd0);
      end
      last_rv_cyc = cyc;
    end
    if (!if_rvalid) chk("if_rdata_zero", if_rdata, 32'd0);
    if (!d_rvalid) chk("d_rdata_zero", d_rdata, 32'd0);
  end

  task automatic expect_access(input logic own_d, input logic [31:0] addr, input logic [3:0] we,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int lat, input int gap);
    gnt_q.push_back('{own_d, gap});
    rsp_q.push_back('{own_d, addr, we, wdata, rdata, lat});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((gnt_q.size() != 0 || rsp_q.size() != 0 || if_q.size() != 0 ||
            d_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s drain timeout: gnt_q=%0d rsp_q=%0d busy=%b", name,
               gnt_q.size(), rsp_q.size(), busy);
      gnt_q.delete(); rsp_q.delete(); if_q.delete(); d_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1; manual_ack = 1'b0; manual_data = '0; ack_delay = 1; ack_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch only: grant at 0, ack two cycles later, rvalid at cycle 2.
    ack_delay = 1; ack_data = 32'h0050_0093;
    expect_access(1'b0, 32'h40, 4'h0, 32'h0, 32'h0050_0093, 2, 0);
    if_q.push_back('{32'h40, 4'h0, 32'h0});
    drain("fetch_only");

    // Both request: data first, fetch in the IDLE cycle after d_rvalid.
    ack_delay = 2; ack_data = 32'h1234_5678;
    expect_access(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 3, 0);
    expect_access(1'b0, 32'h80, 4'h0, 32'h0, 32'h1234_5678, 3, 1);
    d_q.push_back('{32'h100, 4'hF, 32'hDEAD_BEEF});
    if_q.push_back('{32'h80, 4'h0, 32'h0});
    drain("both_req");

    // Starvation: six data requests against two waiting fetches.
    ack_delay = 1; ack_data = 32'hCAFE_0001;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++)
      expect_access(1'b1, 32'h200 + 32'(4 * k), (k % 2 == 1) ? 4'hF : 4'h0,
                    32'hA000_0000 + 32'(k), 32'hCAFE_0001, 2, (k == 0) ? 0 : 1);
    expect_access(1'b0, 32'h1000, 4'h0, 32'h0, 32'hCAFE_0001, 2, 1);
    for (int k = 4; k < 6; k++)
      expect_access(1'b1, 32'h200 + 32'(4 * k), (k % 2 == 1) ? 4'hF : 4'h0,
                    32'hA000_0000 + 32'(k), 32'hCAFE_0001, 2, 1);
    expect_access(1'b0, 32'h1004, 4'h0, 32'h0, 32'hCAFE_0001, 2, 1);
`else
    for (int k = 0; k < 6; k++)
      expect_access(1'b1, 32'h200 + 32'(4 * k), (k % 2 == 1) ? 4'hF : 4'h0,
                    32'hA000_0000 + 32'(k), 32'hCAFE_0001, 2, (k == 0) ? 0 : 1);
    expect_access(1'b0, 32'h1000, 4'h0, 32'h0, 32'hCAFE_0001, 2, 1);
    expect_access(1'b0, 32'h1004, 4'h0, 32'h0, 32'hCAFE_0001, 2, 1);
`endif
    for (int k = 0; k < 6; k++)
      d_q.push_back('{32'h200 + 32'(4 * k), (k % 2 == 1) ? 4'hF : 4'h0, 32'hA000_0000 + 32'(k)});
    if_q.push_back('{32'h1000, 4'h0, 32'h0});
    if_q.push_back('{32'h1004, 4'h0, 32'h0});
    drain("starvation");

    // Reset in BUSY_D, then a late ack for the aborted access.
    ack_delay = 5; ack_data = 32'h7777_7777;
    gnt_q.push_back('{1'b1, 0});
    d_q.push_back('{32'h300, 4'h3, 32'h55AA_55AA});
    n = 0;
    while (!busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("abort_reached_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; manual_data = 32'hBAD0_BAD0; manual_ack = 1'b1;
    chk("abort_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    manual_ack = 1'b0;
    chk("abort_stays_idle", 32'(busy), 32'd0);
    drain("reset_abort");

    // Stray ack in IDLE, then zero-wait acks.
    manual_data = 32'h1111_1111; manual_ack = 1'b1;
    chk("stray_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    manual_ack = 1'b0;
    chk("stray_no_state_change", 32'(busy), 32'd0);
    ack_delay = 0; ack_data = 32'h0BAD_F00D;
    expect_access(1'b1, 32'h400, 4'h1, 32'h0000_00EE, 32'h0BAD_F00D, 1, 0);
    expect_access(1'b0, 32'h48, 4'h0, 32'h0, 32'h0BAD_F00D, 1, 1);
    d_q.push_back('{32'h400, 4'h1, 32'h0000_00EE});
    if_q.push_back('{32'h48, 4'h0, 32'h0});
    drain("zero_wait");

    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
